gpio_input_capture: RTL and testbench
=====================================

GPIO_INPUT_CAPTURE -- requirements
Module: gpio_input_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles required to accept an input change (10 ms at 50 MHz); legal range 1..2^20-1.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth per input; legal range 2..4.
REQ-003 CLK  in  1  is the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  is the synchronous, active-high reset.
REQ-005 SW  in  18  is the board slide switches, asynchronous, active-high.
REQ-006 KEY  in  4  is the board pushbuttons, asynchronous, active-low (1 = released).
REQ-007 address  in  11  is the core byte address; only address[3:2] is decoded.
REQ-008 MemGPIOWrite  in  1  is the register write strobe, one cycle per write.
REQ-009 write_data  in  32  is the write data.
REQ-010 read_data_GPIO  out  32  is the registered read data.
REQ-011 irq  out  1  is the registered, level-high interrupt request.

Function
REQ-012 Each SW bit shall pass through SYNC_STAGES flops reset to 0; each KEY bit shall pass through SYNC_STAGES flops reset to 1 (released).
REQ-013 Per input: a 20-bit counter shall clear whenever synced value == stable value and increment otherwise; when the mismatch has persisted DEBOUNCE_CYCLES consecutive cycles, the stable value shall take the synced value and the counter shall clear, in the same edge.
REQ-014 A mismatch shorter than DEBOUNCE_CYCLES shall leave the stable value unchanged.
REQ-015 Internal pressed[3:0] = ~stable KEY; state[21:0] = {pressed[3:0], stable SW[17:0]}.
REQ-016 Register map: addr[3:2]=0 DATA (RO) = {10'b0, state}; 1 EVENT (RO, W1C); 2 IRQ_EN (RW, bits[21:0]); 3 PRESS_CNT (RO, write-any clears) = {16'b0, count}.
REQ-017 EVENT[21:18] shall set one cycle after the corresponding pressed bit rises 0->1 (press only, not release); EVENT[17:0] shall set one cycle after the corresponding stable SW bit changes in either direction.
REQ-018 EVENT bits are sticky; a write to EVENT clears bits where write_data is 1; set and clear of the same bit in the same cycle leaves it set.
REQ-019 IRQ_EN write stores write_data[21:0]; upper bits read 0.
REQ-020 irq shall be registered |(EVENT & IRQ_EN), i.e. one cycle after EVENT/IRQ_EN update.
REQ-021 count is 16 bits, increments by the number of keys (0..4) whose press is detected that cycle, wraps modulo 2^16.
REQ-022 A write to PRESS_CNT in the same cycle as presses shall load count with that cycle's press number.
REQ-023 read_data_GPIO shall update every cycle with the register selected by the address of the previous cycle (1-cycle latency); reads have no side effects.
REQ-024 Writes to DATA shall be ignored.
REQ-025 Total latency from a clean raw edge to the DATA bit: SYNC_STAGES + DEBOUNCE_CYCLES cycles to stable, +1 to read_data_GPIO; EVENT +1 after stable, irq +2 after stable.

Reset
REQ-026 On RST: synchronizers per REQ-012, stable SW=0, stable KEY=released, all debounce counters 0, EVENT=0, IRQ_EN=0, count=0, read_data_GPIO=0, irq=0.
REQ-027 RST mid-debounce shall discard the in-progress count; a switch held high through reset shall produce a SW change event DEBOUNCE_CYCLES+SYNC_STAGES+1 cycles after RST falls.
REQ-028 RST has priority over any write in the same cycle.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 SW[5] 0->1 held -> DATA bit5 =1 on read_data_GPIO 7 cycles later; EVENT=0x20 next cycle; irq stays 0 (IRQ_EN=0).
REQ-030 KEY[0] low 3 cycles then high -> DATA, EVENT, count unchanged (glitch rejected).
REQ-031 IRQ_EN=0x40000, KEY[0] pressed and held -> EVENT bit18 set, irq=1 one cycle later; W1C write 0x40000 -> EVENT=0, irq=0 following cycle; release sets no event.
REQ-032 KEY[3:0] all pressed same cycle -> count=4; 65532 further presses -> count wraps to 0.
REQ-033 W1C of EVENT bit18 in the same cycle a new KEY[0] press sets it -> bit18 remains 1.
REQ-034 Assert RST two cycles into a SW[0] debounce -> all outputs 0 next cycle; with SW[0] still high, event bit0 sets 7 cycles after RST release.

Source files
------------

// File: rtl/gpio_input_capture.sv
// Board switch/pushbutton capture: synchronizes and debounces SW and KEY, then exposes
// their state, sticky change events, an interrupt mask and a press counter as four registers.
module gpio_input_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  input  logic [10:0] address,
  input  logic        MemGPIOWrite,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_GPIO,
  output logic        irq
);

  localparam int unsigned N_IN    = 22;
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  // KEY is active-low, so its idle (released) level is 1.
  localparam logic [21:0] IN_IDLE = {4'hF, 18'h0};

  localparam logic [1:0] A_DATA  = 2'd0;
  localparam logic [1:0] A_EVENT = 2'd1;
  localparam logic [1:0] A_IRQEN = 2'd2;
  localparam logic [1:0] A_CNT   = 2'd3;

  function automatic logic [2:0] press_count(input logic [3:0] p);
    press_count = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
  endfunction

  logic [SYNC_STAGES-1:0][21:0] sync_p0;
  logic [21:0]                  synced_p0;
  logic [19:0]                  db_cnt_p1 [N_IN];
  logic [21:0]                  stable_p1;
  logic [21:0]                  state_p1;
  logic [21:0]                  state_p2;
  logic [21:0]                  ev_set;
  logic [2:0]                   npress;
  logic [21:0]                  event_r;
  logic [21:0]                  irq_en_r;
  logic [15:0]                  count_r;
  logic [31:0]                  rd_mux;
  logic                         ev_wr;
  logic                         en_wr;
  logic                         cnt_wr;
  logic                         unused_bits;

  assign unused_bits = ^{address[10:4], address[1:0], write_data[31:22]};

  // Stage p0: metastability synchronizers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= {SYNC_STAGES{IN_IDLE}};
    end else begin
      sync_p0[0] <= {KEY, SW};
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  assign synced_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1: per-input debounce, accepts a change after DEBOUNCE_CYCLES of disagreement
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable_p1 <= IN_IDLE;
      for (int i = 0; i < N_IN; i++) db_cnt_p1[i] <= 20'd0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (synced_p0[i] == stable_p1[i]) begin
          db_cnt_p1[i] <= 20'd0;
        end else if (db_cnt_p1[i] == DB_LAST) begin
          stable_p1[i] <= synced_p0[i];
          db_cnt_p1[i] <= 20'd0;
        end else begin
          db_cnt_p1[i] <= db_cnt_p1[i] + 20'd1;
        end
      end
    end
  end

  assign state_p1 = {~stable_p1[21:18], stable_p1[17:0]};
  // Keys report presses only; switches report both directions.
  assign ev_set   = {state_p1[21:18] & ~state_p2[21:18], state_p1[17:0] ^ state_p2[17:0]};
  assign npress   = press_count(ev_set[21:18]);

  assign ev_wr  = MemGPIOWrite && (address[3:2] == A_EVENT);
  assign en_wr  = MemGPIOWrite && (address[3:2] == A_IRQEN);
  assign cnt_wr = MemGPIOWrite && (address[3:2] == A_CNT);

  always_comb begin
    rd_mux = 32'd0;
    case (address[3:2])
      A_DATA:  rd_mux = {10'd0, state_p1};
      A_EVENT: rd_mux = {10'd0, event_r};
      A_IRQEN: rd_mux = {10'd0, irq_en_r};
      A_CNT:   rd_mux = {16'd0, count_r};
      default: rd_mux = 32'd0;
    endcase
  end

  // Stage p2: edge detect, register file, interrupt and read port
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p2       <= 22'd0;
      event_r        <= 22'd0;
      irq_en_r       <= 22'd0;
      count_r        <= 16'd0;
      irq            <= 1'b0;
      read_data_GPIO <= 32'd0;
    end else begin
      state_p2 <= state_p1;
      // A new event wins over a simultaneous write-one-to-clear.
      event_r  <= (ev_wr ? (event_r & ~write_data[21:0]) : event_r) | ev_set;
      if (en_wr) irq_en_r <= write_data[21:0];
      count_r  <= cnt_wr ? {13'd0, npress} : (count_r + {13'd0, npress});
      irq            <= |(event_r & irq_en_r);
      read_data_GPIO <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Scoreboard bench for gpio_input_capture: reads push expected data/irq, a monitor compares.
// A second instance with a one-cycle debounce exercises the 16-bit press counter wrap.
module tb_gpio_input_capture;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [17:0] SW = 18'd0;
  logic [3:0]  KEY = 4'hF;
  logic [10:0] address = 11'd0;
  logic        MemGPIOWrite = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data_GPIO;
  logic        irq;

  logic [3:0]  wkey = 4'hF;
  logic [31:0] w_rd;
  logic        w_irq;

  always #5 CLK = ~CLK;

  gpio_input_capture #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_dut (
    .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY), .address(address),
    .MemGPIOWrite(MemGPIOWrite), .write_data(write_data),
    .read_data_GPIO(read_data_GPIO), .irq(irq)
  );

  gpio_input_capture #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) u_wrap (
    .CLK(CLK), .RST(RST), .SW(18'd0), .KEY(wkey), .address(11'h00C),
    .MemGPIOWrite(1'b0), .write_data(32'd0),
    .read_data_GPIO(w_rd), .irq(w_irq)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
    bit          inst;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rd_issue = 1'b0;
  bit   rd_pend = 1'b0;

  always @(posedge CLK) rd_pend <= rd_issue;

  always @(negedge CLK) begin
    if (rd_pend) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expectation: read presented but scoreboard empty");
      end else begin
        mon_e = sbq.pop_front();
        n_cmp++;
        if ((mon_e.inst ? w_rd : read_data_GPIO) !== mon_e.data) begin
          n_bad++;
          $display("FAIL %s data: got %h want %h", mon_e.name,
                   mon_e.inst ? w_rd : read_data_GPIO, mon_e.data);
        end
        n_cmp++;
        if ((mon_e.inst ? w_irq : irq) !== mon_e.irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b want %b", mon_e.name,
                   mon_e.inst ? w_irq : irq, mon_e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic q,
                    input string nm, input bit inst = 1'b0);
    exp_t e;
    if (!inst) address = {7'd0, a, 2'd0};
    e.name = nm;
    e.data = d;
    e.irq  = q;
    e.inst = inst;
    sbq.push_back(e);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address      = {7'd0, a, 2'd0};
    write_data   = d;
    MemGPIOWrite = 1'b1;
    tick();
    MemGPIOWrite = 1'b0;
  endtask

  task automatic wrap_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      wkey = 4'h0;
      tick();
      wkey = 4'hF;
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    rd(0, 32'h0, 1'b0, "rst_data");
    rd(1, 32'h0, 1'b0, "rst_event");
    rd(2, 32'h0, 1'b0, "rst_irqen");
    rd(3, 32'h0, 1'b0, "rst_cnt");

    // SW[5] rises: visible on DATA 7 cycles later, EVENT one cycle after that
    SW = 18'h20;
    repeat (6) rd(0, 32'h0, 1'b0, "sw5_pending");
    rd(0, 32'h20, 1'b0, "sw5_data");
    rd(1, 32'h20, 1'b0, "sw5_event");
    wr(1, 32'h20);
    rd(1, 32'h0, 1'b0, "sw5_w1c");
    wr(0, 32'hFFFF_FFFF);
    rd(0, 32'h20, 1'b0, "data_ro");
    wr(2, 32'hFFFF_FFFF);
    rd(2, 32'h003F_FFFF, 1'b0, "irqen_mask");
    wr(2, 32'h0004_0000);
    rd(2, 32'h0004_0000, 1'b0, "irqen_set");

    // 3-cycle KEY[0] glitch is rejected
    KEY = 4'hE;
    idle(3);
    KEY = 4'hF;
    idle(10);
    rd(0, 32'h20, 1'b0, "glitch_data");
    rd(1, 32'h0, 1'b0, "glitch_event");
    rd(3, 32'h0, 1'b0, "glitch_cnt");

    // KEY[0] press with IRQ_EN bit18
    KEY = 4'hE;
    idle(6);
    rd(1, 32'h0, 1'b0, "press_event_early");
    rd(1, 32'h0004_0000, 1'b1, "press_event_irq");
    wr(1, 32'h0004_0000);
    rd(1, 32'h0, 1'b0, "press_w1c");
    KEY = 4'hF;
    idle(10);
    rd(1, 32'h0, 1'b0, "release_no_event");
    rd(3, 32'h1, 1'b0, "press_cnt1");
    rd(0, 32'h20, 1'b0, "release_data");

    // W1C coincident with a new press: bit stays set
    KEY = 4'hE;
    idle(6);
    wr(1, 32'h0004_0000);
    rd(1, 32'h0004_0000, 1'b1, "w1c_vs_set");
    KEY = 4'hF;
    idle(10);
    wr(1, 32'h0004_0000);
    rd(1, 32'h0, 1'b0, "w1c_after");

    // All four keys at once, counter write in the detection cycle loads 4
    KEY = 4'h0;
    idle(6);
    wr(3, 32'h0);
    rd(3, 32'h4, 1'b1, "cnt_load4");
    rd(1, 32'h003C_0000, 1'b1, "ev_all_keys");
    rd(0, 32'h003C_0020, 1'b1, "data_all_keys");
    KEY = 4'hF;
    idle(10);
    rd(1, 32'h003C_0000, 1'b1, "ev_after_release");
    rd(3, 32'h4, 1'b1, "cnt_after_release");
    wr(1, 32'hFFFF_FFFF);
    rd(1, 32'h0, 1'b0, "ev_clear_all");
    wr(3, 32'h0000_007B);
    rd(3, 32'h0, 1'b0, "cnt_clear");

    // Reset two cycles into a SW[0] debounce, with a write racing the reset
    SW = 18'h21;
    idle(4);
    RST = 1'b1;
    wr(2, 32'hFFFF_FFFF);
    rd(0, 32'h0, 1'b0, "rst_mid_outputs");
    RST = 1'b0;
    repeat (7) rd(1, 32'h0, 1'b0, "post_rst_pending");
    rd(1, 32'h21, 1'b0, "post_rst_event");
    rd(2, 32'h0, 1'b0, "rst_beats_write");
    rd(0, 32'h21, 1'b0, "post_rst_data");
    rd(3, 32'h0, 1'b0, "post_rst_cnt");

    // Counter wrap on the fast-debounce instance
    wrap_rounds(1);
    idle(6);
    rd(3, 32'h4, 1'b0, "wrap_first4", 1'b1);
    wrap_rounds(16382);
    idle(6);
    rd(3, 32'h0000_FFFC, 1'b0, "wrap_65532", 1'b1);
    wrap_rounds(1);
    idle(6);
    rd(3, 32'h0, 1'b0, "wrap_zero", 1'b1);

    idle(3);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
